addsub_arbiter: RTL and testbench
=================================

// Module: addsub_arbiter
// PURPOSE
//  Shares one adder_substractor datapath between NREQ requesters.
//  Round-robin arbitration; a 3-state FSM sequences each operation
//  (grant/latch -> execute -> respond). Sits between requesting units and
//  the shared ALU, so a single n-bit add/sub serves the whole cluster.
// PARAMETERS
//  n     4  operand/result width in bits, passed to adder_substractor
//  NREQ  4  number of requesters (>=2); index width IW = $clog2(NREQ)
// PORTS
//  clk       in   1       rising-edge clock, the only clock
//  rst       in   1       asynchronous, active-high reset
//  req       in   NREQ    req[i]=1: requester i has a pending operation
//  x_in      in   NREQ*n  operand x; requester i at bits [i*n +: n]
//  y_in      in   NREQ*n  operand y; same packing as x_in
//  s_in      in   NREQ    op select: 0 = x+y, 1 = x-y
//  gnt       out  NREQ    one-hot, 1-cycle pulse: operands of i captured
//  done      out  NREQ    one-hot, 1-cycle pulse: result for i valid
//  f_out     out  n       result; holds until the next done pulse
//  cout_out  out  1       carry-out of x + (y^{n{s}}) + s
//  ov_out    out  1       signed two's-complement overflow
//  busy      out  1       1 in EXEC and RESP states
// BEHAVIOUR
//  Reset (async, takes effect immediately): state=IDLE; gnt, done, busy,
//   f_out, cout_out, ov_out = 0; round-robin pointer = 0; operand regs = 0.
//  FSM states:
//   IDLE: if |req, pick winner w = first set req[] at or after pointer,
//     wrapping modulo NREQ. On the clock edge: latch x/y/s of w and w's
//     index, pulse gnt[w] in the next cycle, go to EXEC, pointer = w+1 mod NREQ.
//     If req==0, stay in IDLE.
//   EXEC: adder_substractor is driven from the latched operand regs. At the
//     edge, register f/cout/ov into the output regs and go to RESP.
//   RESP: done[w]=1 for this cycle only; go to IDLE.
//  Latency: req sampled at edge k -> gnt at k+1 -> done and result at k+2.
//   Throughput is 1 op per 3 cycles; a back-to-back req is sampled in IDLE.
//  Handshake: the requester holds req, x, y and s stable until it sees
//   gnt[i]. After gnt it may change them freely. If req[i] is still high
//   after gnt, that is a new request.
//  req[i] dropped before gnt: the request is withdrawn, no error.
//  Simultaneous requests: exactly one grant; the others wait. No requester
//   waits more than NREQ-1 grants (fairness).
//  Pointer wrap: a grant to NREQ-1 sets pointer = 0.
//  Width: every result is n bits; the carry appears only on cout_out.
//   ov = (x[n-1] == y'[n-1]) && (f[n-1] != x[n-1]), where y' = y^{n{s}}.
//  Reset during EXEC/RESP aborts the operation. No done pulse is produced,
//   and the requester must re-request.
//  No X on any output after reset. gnt and done are never multi-hot.
// CONFIGURATION
//  ADDSUB_ARB_SAT_EN defined: when ov=1 in EXEC, f_out clamps to signed
//   max {0,{n-1{1}}} if x[n-1]=0, else signed min {1,{n-1{0}}}. ov_out
//   still reports the overflow.
//  ADDSUB_ARB_SAT_EN undefined: f_out is the wrapped n-bit result.
// STRUCTURE
//  Shared package addsub_pkg: FSM state typedef/localparams (ST_IDLE,
//   ST_EXEC, ST_RESP, 2-bit encoding) and the op-select constants
//   OP_ADD=1'b0, OP_SUB=1'b1.
//  Sub-module: one existing adder_substractor #(.n(n)) instance, driven
//   from the latched x, y and s registers. Arbitration logic is a local
//   function, not a separate module.
// TESTING (n=4, NREQ=4)
//  1 Single op: req=0001, x0=6, y0=7, s0=1. Expect gnt=0001 at k+1 and
//    done=0001 at k+2, f=4'hF, cout=0, ov=0.
//  2 Add with overflow: x=6, y=7, s=0. Expect f=4'hD, cout=0, ov=1.
//    With ADDSUB_ARB_SAT_EN: f=4'h7, ov=1.
//  3 Round robin: req=1111 held, operands x_i=i, y_i=1, s=0. Expect grant
//    order 0,1,2,3,0 every 3 cycles, with results 1,2,3,4.
//  4 Fairness/skip: pointer=2, req=0011. Expect grant to 0 (wrap), then 1.
//  5 Reset mid-op: assert rst during EXEC of x=3, y=4. Expect outputs = 0
//    immediately, no done pulse, pointer=0. After release, a re-request
//    gives f=7.
//  6 Withdraw: req[2] pulsed for one cycle while the arbiter is busy with
//    another requester. Expect no gnt[2] and no done[2].

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared FSM state encoding and op-select constants for the add/sub arbiter slice.
// Latency: none (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_substractor.sv
// Purpose: combinational n-bit add/sub, f = x + (y ^ {n{s}}) + s, with carry and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module adder_substractor
    import addsub_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         s,
    output logic [n-1:0] f,
    output logic         cout,
    output logic         ov
);

    logic [n-1:0] yx;
    logic [n:0]   sum;

    assign yx   = (s == OP_ADD) ? y : ~y;
    assign sum  = {1'b0, x} + {1'b0, yx} + {{n{1'b0}}, s};
    assign f    = sum[n-1:0];
    assign cout = sum[n];
    // Same-sign operands producing an opposite-sign result is a signed overflow.
    assign ov   = (x[n-1] == yx[n-1]) && (f[n-1] != x[n-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// Purpose: round-robin share of one adder_substractor among NREQ requesters; ADDSUB_ARB_SAT_EN enables saturation.
// Latency: req sampled at edge k -> gnt pulse after k -> done/result after k+1; one op per 3 cycles.
// Backpressure: requesters hold req/operands until gnt; losers simply wait, a dropped req is withdrawn.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int n    = 4,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*n-1:0] x_in,
    input  logic [NREQ*n-1:0] y_in,
    input  logic [NREQ-1:0]   s_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [n-1:0]      f_out,
    output logic              cout_out,
    output logic              ov_out,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [n-1:0]  xr;
    logic [n-1:0]  yr;
    logic          sr;
    logic [n-1:0]  alu_f;
    logic          alu_cout;
    logic          alu_ov;
    logic [n-1:0]  f_nxt;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    // First set request at or after the pointer, wrapping; iterate downward so the nearest wins.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % NREQ;
            if (r[j]) begin
                res = {1'b1, IW'(j)};
            end
        end
        return res;
    endfunction

    assign {pick_vld, pick_idx} = rr_pick(req, ptr);

    adder_substractor #(.n(n)) u_alu (
        .x    (xr),
        .y    (yr),
        .s    (sr),
        .f    (alu_f),
        .cout (alu_cout),
        .ov   (alu_ov)
    );

`ifdef ADDSUB_ARB_SAT_EN
    always_comb begin
        f_nxt = alu_f;
        if (alu_ov) begin
            f_nxt = xr[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
        end
    end
`else
    assign f_nxt = alu_f;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = pick_vld ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        busy = 1'b0;
        case (state)
            ST_EXEC: begin
                gnt[win] = 1'b1;
                busy     = 1'b1;
            end
            ST_RESP: begin
                done[win] = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            win <= '0;
            xr  <= '0;
            yr  <= '0;
            sr  <= 1'b0;
        end else if (state == ST_IDLE && pick_vld) begin
            xr  <= x_in[int'(pick_idx)*n +: n];
            yr  <= y_in[int'(pick_idx)*n +: n];
            sr  <= s_in[pick_idx];
            win <= pick_idx;
            ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Result registers hold their value until the next operation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_out    <= '0;
            cout_out <= 1'b0;
            ov_out   <= 1'b0;
        end else if (state == ST_EXEC) begin
            f_out    <= f_nxt;
            cout_out <= alu_cout;
            ov_out   <= alu_ov;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter (n=4, NREQ=4): directed cases then randomized traffic.
module tb_addsub_arbiter;
    import addsub_pkg::*;

    typedef struct {
        int         idx;
        int         cyc;
        logic [3:0] f;
        logic       c;
        logic       v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [3:0]  s_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  f_out;
    logic        cout_out;
    logic        ov_out;
    logic        busy;

    logic [3:0]  keep;
    logic        fin;
    exp_t        gq[$];
    exp_t        dq[$];
    int          cyc;
    int          free_in;
    int          mptr;
    int          n_cmp;
    int          n_bad;

    addsub_arbiter #(.n(4), .NREQ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .s_in     (s_in),
        .gnt      (gnt),
        .done     (done),
        .f_out    (f_out),
        .cout_out (cout_out),
        .ov_out   (ov_out),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Reference arithmetic on plain integers: signed overflow is "true result out of range".
    function automatic exp_t ref_op(input int w, input int xv, input int yv, input int sv, input int c);
        exp_t e;
        int   sx;
        int   sy;
        int   full;
        int   tru;
        sx = (xv > 7) ? xv - 16 : xv;
        sy = (yv > 7) ? yv - 16 : yv;
        if (sv != 0) begin
            full = xv + (15 - yv) + 1;
            tru  = sx - sy;
        end else begin
            full = xv + yv;
            tru  = sx + sy;
        end
        e.idx = w;
        e.cyc = c;
        e.f   = 4'(full % 16);
        e.c   = (full >= 16);
        e.v   = (tru > 7) || (tru < -8);
`ifdef ADDSUB_ARB_SAT_EN
        if (e.v) e.f = (sx >= 0) ? 4'h7 : 4'h8;
`endif
        return e;
    endfunction

    // Model: an idle arbiter grants the nearest pending requester from its pointer, then is busy two cycles.
    initial begin
        cyc     = 0;
        free_in = 0;
        mptr    = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                gq.delete();
                dq.delete();
                free_in = 0;
                mptr    = 0;
            end else begin
                cyc++;
                if (free_in > 0) begin
                    free_in--;
                end else if (req != 4'b0) begin
                    int   w;
                    bit   found;
                    exp_t e;
                    w     = 0;
                    found = 0;
                    for (int k = 0; k < 4; k++) begin
                        int j;
                        j = (mptr + k) % 4;
                        if (!found && req[j]) begin
                            w     = j;
                            found = 1;
                        end
                    end
                    e = ref_op(w, int'(x_in[w*4 +: 4]), int'(y_in[w*4 +: 4]), int'(s_in[w]), cyc);
                    gq.push_back(e);
                    e.cyc = cyc + 1;
                    dq.push_back(e);
                    mptr    = (w + 1) % 4;
                    free_in = 2;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: checks every output away from the active edge, popping the scoreboard on gnt/done.
    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (rst) begin
                chk("reset_outputs", 32'({gnt, done, f_out, cout_out, ov_out, busy}), 32'd0);
            end else begin
                chk("busy", 32'(busy), 32'(free_in != 0));
                if (gnt != 4'b0) begin
                    if (gq.size() == 0) begin
                        chk("gnt_spurious", 32'(gnt), 32'd0);
                    end else begin
                        e = gq.pop_front();
                        chk("gnt_onehot", 32'(gnt), 32'd1 << e.idx);
                        chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                    e = gq.pop_front();
                    chk("gnt_missing", 32'(gnt), 32'd1 << e.idx);
                end
                if (done != 4'b0) begin
                    if (dq.size() == 0) begin
                        chk("done_spurious", 32'(done), 32'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("done_onehot", 32'(done), 32'd1 << e.idx);
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        chk("f_out", 32'(f_out), 32'(e.f));
                        chk("cout_out", 32'(cout_out), 32'(e.c));
                        chk("ov_out", 32'(ov_out), 32'(e.v));
                    end
                end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                    e = dq.pop_front();
                    chk("done_missing", 32'(done), 32'd1 << e.idx);
                end
            end
            if (fin) begin
                chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
                chk("done_queue_drained", 32'(dq.size()), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    task automatic set_op(input int i, input int xv, input int yv, input int sv);
        x_in[i*4 +: 4] = 4'(xv);
        y_in[i*4 +: 4] = 4'(yv);
        s_in[i]        = (sv != 0);
    endtask

    // Advance to the next falling edge; a requester that sees its grant drops req unless told to keep it.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (gnt[i] && !keep[i]) req[i] = 1'b0;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        x_in = '0;
        y_in = '0;
        s_in = '0;
        keep = '0;
        fin  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Subtract 6-7 on requester 0.
        set_op(0, 6, 7, OP_SUB);
        req[0] = 1'b1;
        repeat (5) tick();

        // Add 6+7 overflows.
        set_op(0, 6, 7, OP_ADD);
        req[0] = 1'b1;
        repeat (5) tick();

        // All four held: rotation 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_op(i, i, 1, OP_ADD);
        keep = 4'b1111;
        req  = 4'b1111;
        repeat (15) tick();
        req  = '0;
        keep = '0;
        repeat (4) tick();

        // Pointer moved to 2 by a grant to 1; then 0 and 1 together must wrap to 0 first.
        set_op(1, 2, 3, OP_ADD);
        req[1] = 1'b1;
        repeat (4) tick();
        set_op(0, 9, 4, OP_SUB);
        set_op(1, 8, 8, OP_ADD);
        req = 4'b0011;
        repeat (8) tick();

        // Requester 2 pulses for one cycle while requester 0 is being served.
        set_op(0, 5, 5, OP_SUB);
        req[0] = 1'b1;
        tick();
        set_op(2, 1, 1, OP_ADD);
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        repeat (5) tick();

        // Reset during EXEC of requester 1; pointer must restart at 0 afterwards.
        set_op(1, 3, 4, OP_ADD);
        req[1] = 1'b1;
        tick();
        #2 rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        set_op(1, 3, 4, OP_ADD);
        set_op(2, 7, 1, OP_ADD);
        req = 4'b0110;
        repeat (8) tick();

        // Randomized traffic with re-requests and withdrawals.
        for (int c = 0; c < 500; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        set_op(i, $urandom_range(15), $urandom_range(15), $urandom_range(1));
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(31) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end

        req = '0;
        repeat (8) tick();
        fin = 1'b1;
    end

endmodule
